ram_ctrl: RTL and testbench
===========================

Name: ram_ctrl

Overview:
- Parametrised successor to the single-cycle data RAM that sits between the mips core and the memory array.
- Adds configurable width, depth and wait states, and a ready handshake so the core can stall on slow memory.
- Keeps byte-lane select writes, and adds lane-masked reads and out-of-range address detection.
- Instantiated in the cpu top in place of the fixed RAM; the mips ram_* ports connect directly, plus ready and addr_error.

Parameters:
DATA_WIDTH, 32, data bus width in bits; must be a multiple of 8, at least 8
DEPTH, 1024, number of DATA_WIDTH-bit words; power of two, at least 2
ADDR_WIDTH, 32, byte-address width
WAIT_CYCLES, 1, extra cycles inserted before each access completes; 0 to 15
SEL_WIDTH, DATA_WIDTH/8, byte-lane count (derived; do not override)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
enabler  input  1  request strobe; sampled only in IDLE
write_enabler  input  1  1 = write, 0 = read; sampled with enabler
addr  input  ADDR_WIDTH  byte address
select  input  SEL_WIDTH  byte-lane enables; bit i maps to data bits [8i+7:8i]
data_input  input  DATA_WIDTH  write data
data_output  output  DATA_WIDTH  read data; valid while ready=1, held until the next completion
ready  output  1  one-cycle completion pulse
addr_error  output  1  high with ready when the completed access was out of range
busy  output  1  high while a request is in flight (state BUSY)

Behaviour:
- Reset, synchronous and active-high:
  - state=IDLE, count=0, data_output=0, ready=0, addr_error=0, busy=0.
  - Memory array contents are not cleared.
- Word index = addr[OFS +: log2(DEPTH)], where OFS = log2(SEL_WIDTH). The low OFS address bits are ignored.
- Out of range: any addr bit at or above OFS+log2(DEPTH) is nonzero.
- State IDLE:
  - ready=0 and addr_error=0, except during the single completion cycle.
  - If enabler=1 at a rising edge: latch addr, select, data_input and write_enabler; set count=0; go to BUSY; busy=1.
  - If enabler=0: remain in IDLE.
- State BUSY:
  - Inputs are ignored; the latched copies are used.
  - If count < WAIT_CYCLES: count++.
  - If count == WAIT_CYCLES: perform the access, pulse ready=1 on the next cycle, set busy=0, go to IDLE.
- Latency: from the accept edge k, ready is high during the cycle after edge k+WAIT_CYCLES+1.
- Throughput: a request asserted in the ready-high cycle is accepted, because the state is IDLE. Minimum request period is WAIT_CYCLES+2 cycles.
- Write completion:
  - For each lane i with select[i]=1, mem[idx] lane i <= latched data lane i; other lanes are unchanged.
  - select=0 is a legal no-op write that still completes with ready.
  - data_output is unchanged on a write.
- Read completion:
  - data_output lane i = mem[idx] lane i if select[i]=1, else 0.
  - select=0 yields data_output=0.
- Out-of-range completion: no write occurs; data_output=0 on a read; addr_error=1 together with ready.
- enabler held high continuously: each request is accepted at the first IDLE edge; no request is queued.
- Reset during BUSY: the pending access is abandoned, with no write and no ready pulse. State goes to IDLE the following cycle.
- Reset has priority over a simultaneous enabler.

Test Plan:
- WAIT_CYCLES=1. Write addr=0x10, select=4'b1111, data_input=0xDEADBEEF, then read addr=0x10, select=4'b1111 -> ready high 2 cycles after each accept edge; read data_output=0xDEADBEEF; addr_error=0.
- Byte lanes. Write 0x11223344 with select=1111, then write 0xAABBCCDD to the same word with select=0101, then read with select=1111 -> 0x11BB33DD. Read with select=0011 -> 0x000033DD.
- Out of range, DEPTH=1024. Write to addr=0x1000 -> ready=1 and addr_error=1; a read of addr=0x0 (aliased index) is unchanged. A read of 0x1000 returns 0 with addr_error=1.
- Back-to-back, WAIT_CYCLES=0. Hold enabler=1 for 8 cycles -> exactly 4 ready pulses, one every 2 cycles; busy alternates 1,0.
- Reset mid-access, WAIT_CYCLES=3. Write 0x5 to addr=0x20, then assert rst one cycle after accept -> no ready pulse; busy=0 after reset. A subsequent read of 0x20 returns its prior value (0x0 after a prior write of 0).
- Ignored inputs while BUSY. Change addr/data_input during BUSY -> the completed access uses the latched values.

Source files
------------

// File: rtl/ram_ctrl.sv
// ram_ctrl: parametrised data RAM controller for the mips core.
//   Accepts one request at a time. The request is latched on acceptance and
//   completes WAIT_CYCLES+1 cycles later with a one-cycle ready pulse.
//   Writes are byte-lane masked by select. Reads return only the selected
//   lanes, with the other lanes zeroed. Any address bit above the word-index
//   field marks the access out of range: it does not write, a read returns 0,
//   and addr_error is raised together with ready.
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   enabler           request strobe, sampled only while idle
//   write_enabler     1 = write, 0 = read (sampled with enabler)
//   addr              byte address
//   select            byte-lane enables; bit i covers data bits [8i+7:8i]
//   data_input        write data
//   data_output       read data, held until the next read completion
//   ready             one-cycle completion pulse
//   addr_error        completed access was out of range (valid with ready)
//   busy              a request is in flight
module ram_ctrl #(
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 1024,
   parameter int ADDR_WIDTH  = 32,
   parameter int WAIT_CYCLES = 1,
   parameter int SEL_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enabler,
   input  logic                  write_enabler,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [SEL_WIDTH-1:0]  select,
   input  logic [DATA_WIDTH-1:0] data_input,
   output logic [DATA_WIDTH-1:0] data_output,
   output logic                  ready,
   output logic                  addr_error,
   output logic                  busy
);

   localparam int OFS = $clog2(SEL_WIDTH);
   localparam int IW  = $clog2(DEPTH);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t r_state, w_next;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic [ADDR_WIDTH-1:0] r_addr;
   logic [SEL_WIDTH-1:0]  r_sel;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_we;
   logic [3:0]            r_count;
   logic [DATA_WIDTH-1:0] r_dout;
   logic                  r_ready;
   logic                  r_err;

   logic                  w_accept;
   logic                  w_complete;
   logic                  w_oor;
   logic [IW-1:0]         w_idx;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_unused_addr;

   assign w_idx = r_addr[OFS +: IW];
   // Everything above the word-index field must be zero to be in range.
   assign w_oor = (r_addr >> (OFS + IW)) != '0;
   // The byte-offset bits below the index only pick a byte within a word,
   // and lanes are chosen by select, so those bits are deliberately ignored.
   assign w_unused_addr = ^r_addr;

   // Next-state logic
   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      w_complete = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (enabler) begin
               w_accept = 1'b1;
               w_next   = S_BUSY;
            end
         end
         S_BUSY: begin
            if (r_count == 4'(WAIT_CYCLES)) begin
               w_complete = 1'b1;
               w_next     = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Lane-masked read of the latched word
   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < SEL_WIDTH; i++)
         if (r_sel[i]) w_rdata[8*i +: 8] = r_mem[w_idx][8*i +: 8];
   end

   // Request latch, wait counter and registered response
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr  <= '0;
         r_sel   <= '0;
         r_wdata <= '0;
         r_we    <= 1'b0;
         r_count <= '0;
         r_dout  <= '0;
         r_ready <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_ready <= w_complete;
         r_err   <= w_complete & w_oor;
         if (w_accept) begin
            r_addr  <= addr;
            r_sel   <= select;
            r_wdata <= data_input;
            r_we    <= write_enabler;
            r_count <= '0;
         end else if (r_state == S_BUSY && !w_complete) begin
            r_count <= r_count + 4'd1;
         end
         // Out-of-range reads still update data_output, to zero.
         if (w_complete && !r_we)
            r_dout <= w_oor ? '0 : w_rdata;
      end
   end

   // Memory array is never cleared; reset only abandons a pending write.
   always_ff @(posedge clk) begin
      if (!rst && w_complete && r_we && !w_oor) begin
         for (int i = 0; i < SEL_WIDTH; i++)
            if (r_sel[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
      end
   end

   assign data_output = r_dout;
   assign ready       = r_ready;
   assign addr_error  = r_err;
   assign busy        = (r_state == S_BUSY);

endmodule

// File: tb/tb_ram_ctrl.sv
module tb_ram_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Three instances: WAIT_CYCLES = 1, 0, 3
   logic        rst  [3];
   logic        en   [3];
   logic        we   [3];
   logic [31:0] addr [3];
   logic [3:0]  sel  [3];
   logic [31:0] din  [3];
   logic [31:0] dout [3];
   logic        rdy  [3];
   logic        aerr [3];
   logic        bsy  [3];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      ram_ctrl #(
         .DATA_WIDTH(32), .DEPTH(1024), .ADDR_WIDTH(32),
         .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3))
      ) u_dut (
         .clk(clk), .rst(rst[g]), .enabler(en[g]), .write_enabler(we[g]),
         .addr(addr[g]), .select(sel[g]), .data_input(din[g]),
         .data_output(dout[g]), .ready(rdy[g]), .addr_error(aerr[g]),
         .busy(bsy[g])
      );
   end

   int total = 0;
   int bad   = 0;

   function automatic int wait_of(input int d);
      return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // One complete request; checks completion latency, returns sampled outputs.
   task automatic xact(input int d, input logic w, input logic [31:0] a,
                       input logic [3:0] s, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er);
      int lat;
      @(negedge clk);
      en[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; din[d] = wd;
      @(posedge clk);
      @(negedge clk);
      en[d] = 1'b0;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!rdy[d] && lat < 40);
      check("latency", lat, wait_of(d) + 1);
      rd = dout[d];
      er = aerr[d];
   endtask

   // Reference model: 16 words at byte addresses 0x00..0x3F
   logic [31:0] model [16];
   logic [31:0] exp_dout;

   function automatic logic [31:0] lanes(input logic [3:0] s);
      logic [31:0] m = 0;
      for (int i = 0; i < 4; i++) if (s[i]) m = m + (32'hFF << (8 * i));
      return m;
   endfunction

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [3:0]  s;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vt [13];

   initial begin
      logic [31:0] rd;
      logic        er;
      int          pulses;

      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b1; en[d] = 1'b0; we[d] = 1'b0;
         addr[d] = '0; sel[d] = '0; din[d] = '0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;

      // Reset state
      for (int d = 0; d < 3; d++) begin
         check("rst_dout", dout[d], 0);
         check("rst_flags", {29'd0, rdy[d], aerr[d], bsy[d]}, 0);
      end

      // Directed table on the WAIT_CYCLES=1 instance.
      // Write rows expect data_output to keep the previous read value.
      vt[0]  = '{1'b1, 32'h10,   4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
      vt[1]  = '{1'b0, 32'h10,   4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
      vt[2]  = '{1'b1, 32'h20,   4'b1111, 32'h11223344, 32'hDEADBEEF, 1'b0};
      vt[3]  = '{1'b1, 32'h20,   4'b0101, 32'hAABBCCDD, 32'hDEADBEEF, 1'b0};
      vt[4]  = '{1'b0, 32'h20,   4'b1111, 32'h0,        32'h11BB33DD, 1'b0};
      vt[5]  = '{1'b0, 32'h20,   4'b0011, 32'h0,        32'h000033DD, 1'b0};
      vt[6]  = '{1'b1, 32'h0,    4'b1111, 32'hCAFEF00D, 32'h000033DD, 1'b0};
      vt[7]  = '{1'b1, 32'h1000, 4'b1111, 32'h12345678, 32'h000033DD, 1'b1};
      vt[8]  = '{1'b0, 32'h0,    4'b1111, 32'h0,        32'hCAFEF00D, 1'b0};
      vt[9]  = '{1'b0, 32'h1000, 4'b1111, 32'h0,        32'h0,        1'b1};
      vt[10] = '{1'b1, 32'h20,   4'b0000, 32'hFFFFFFFF, 32'h0,        1'b0};
      vt[11] = '{1'b0, 32'h22,   4'b1111, 32'h0,        32'h11BB33DD, 1'b0};
      vt[12] = '{1'b0, 32'h20,   4'b0000, 32'h0,        32'h0,        1'b0};
      for (int i = 0; i < 13; i++) begin
         xact(0, vt[i].w, vt[i].a, vt[i].s, vt[i].wd, rd, er);
         check($sformatf("vec%0d_data", i), rd, vt[i].exp_rd);
         check($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vt[i].exp_err});
      end
      @(negedge clk);
      check("ready_one_cycle", {31'd0, rdy[0]}, 0);

      // Randomised traffic against the model
      for (int i = 0; i < 16; i++) begin
         xact(0, 1'b1, i * 4, 4'hF, 32'h0, rd, er);
         model[i] = 32'h0;
      end
      exp_dout = rd;
      for (int n = 0; n < 60; n++) begin
         logic        w;
         logic [31:0] a, wd;
         logic [3:0]  s;
         int          idx;
         logic        oor;
         w   = 1'($urandom_range(0, 1));
         idx = $urandom_range(0, 15);
         a   = idx * 4 + $urandom_range(0, 3);
         oor = ($urandom_range(0, 7) == 0);
         if (oor) a = a | (32'h1 << $urandom_range(12, 31));
         s   = 4'($urandom_range(0, 15));
         wd  = $urandom;
         xact(0, w, a, s, wd, rd, er);
         if (w) begin
            if (!oor) model[idx] = (model[idx] & ~lanes(s)) | (wd & lanes(s));
         end else begin
            exp_dout = oor ? 32'h0 : (model[idx] & lanes(s));
         end
         check("rnd_data", rd, exp_dout);
         check("rnd_err", {31'd0, er}, {31'd0, oor});
      end

      // Back-to-back, WAIT_CYCLES=0: enabler held for 8 cycles
      @(negedge clk);
      en[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0; sel[1] = 4'hF;
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (rdy[1]) pulses++;
         check($sformatf("b2b_busy%0d", i), {31'd0, bsy[1]}, {31'd0, (i % 2 == 0)});
         check($sformatf("b2b_ready%0d", i), {31'd0, rdy[1]}, {31'd0, (i % 2 == 1)});
      end
      en[1] = 1'b0;
      check("b2b_pulses", pulses, 4);

      // Reset mid-access, WAIT_CYCLES=3
      xact(2, 1'b1, 32'h20, 4'hF, 32'h0, rd, er);
      @(negedge clk);
      en[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; sel[2] = 4'hF; din[2] = 32'h5;
      @(posedge clk);
      @(negedge clk);
      en[2] = 1'b0; rst[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst[2] = 1'b0;
      check("rst_mid_busy", {31'd0, bsy[2]}, 0);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (rdy[2]) pulses++;
      end
      check("rst_mid_no_ready", pulses, 0);
      xact(2, 1'b0, 32'h20, 4'hF, 32'h0, rd, er);
      check("rst_mid_data", rd, 32'h0);

      // Reset wins over a simultaneous request
      @(negedge clk);
      rst[2] = 1'b1; en[2] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst[2] = 1'b0; en[2] = 1'b0;
      check("rst_priority", {31'd0, bsy[2]}, 0);

      // Inputs changed while busy must not affect the access
      xact(2, 1'b1, 32'h44, 4'hF, 32'h0, rd, er);
      @(negedge clk);
      en[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h40; sel[2] = 4'hF; din[2] = 32'h600DF00D;
      @(posedge clk);
      @(negedge clk);
      en[2] = 1'b0; addr[2] = 32'h44; din[2] = 32'h00000BAD; sel[2] = 4'h1; we[2] = 1'b0;
      pulses = 0;
      while (!rdy[2] && pulses < 40) begin
         @(posedge clk);
         @(negedge clk);
         pulses++;
      end
      check("busy_ign_lat", pulses, 4);
      xact(2, 1'b0, 32'h40, 4'hF, 32'h0, rd, er);
      check("busy_ign_40", rd, 32'h600DF00D);
      xact(2, 1'b0, 32'h44, 4'hF, 32'h0, rd, er);
      check("busy_ign_44", rd, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
